// File: rtl/sik_defs_pkg.sv
// Shared sik definitions: word/address widths, responder state encodings, port select.
package sik_defs;

    localparam int unsigned WORD   = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic P_I = 1'b0;
    localparam logic P_D = 1'b1;

endpackage

// File: rtl/sik_mem_array.sv
// Single-port synchronous RAM, read-first; contents are not reset.
module sik_mem_array #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sik_mem_responder.sv
// Wait-stated memory responder serving the sik fetch (I) and load/store (D) channels,
// one outstanding request, D-priority arbitration with a fairness flag for I.
module sik_mem_responder #(
    parameter int unsigned ADDR_W = sik_defs::ADDR_W,
    parameter int unsigned DATA_W = sik_defs::WORD,
    parameter int unsigned WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              irdy,
    output logic              ivalid,
    output logic [DATA_W-1:0] idata,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic              drdy,
    output logic              dvalid,
    output logic [DATA_W-1:0] drdata,
    output logic              busy
);
    import sik_defs::*;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              fair;
    logic              port_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] idata_q;
    logic [DATA_W-1:0] drdata_q;

    logic              accept;
    logic              grant_d;
    logic              enter_resp;
    logic              resp_port;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // The RAM is read (and written) on the edge entering RESP. With WAIT=0 that is
    // the accept edge itself, so the live request drives the RAM rather than the latches.
    always_comb begin
        accept     = ((state == S_IDLE) || (state == S_RESP)) && (ireq || dreq);
        grant_d    = dreq && !(ireq && fair);
        enter_resp = 1'b0;
        resp_port  = port_q;
        if (accept) begin
            ram_addr   = grant_d ? daddr : iaddr;
            ram_wdata  = dwdata;
            ram_we     = grant_d && dwe && (WAIT == 0);
            enter_resp = (WAIT == 0);
            resp_port  = grant_d ? P_D : P_I;
        end else begin
            ram_addr   = addr_q;
            ram_wdata  = wdata_q;
            ram_we     = (state == S_WAIT) && (cnt == 4'd1) && (port_q == P_D) && we_q;
            enter_resp = (state == S_WAIT) && (cnt == 4'd1);
        end
        ram_we = ram_we && !reset;
    end

    sik_mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            fair     <= 1'b0;
            port_q   <= P_I;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            idata_q  <= '0;
            drdata_q <= '0;
            irdy     <= 1'b0;
            drdy     <= 1'b0;
            ivalid   <= 1'b0;
            dvalid   <= 1'b0;
        end else begin
            irdy   <= 1'b0;
            drdy   <= 1'b0;
            ivalid <= 1'b0;
            dvalid <= 1'b0;
            if (ivalid) begin
                idata_q <= ram_rdata;
            end
            if (dvalid) begin
                drdata_q <= drdata;
            end

            case (state)
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                port_q  <= grant_d ? P_D : P_I;
                we_q    <= grant_d && dwe;
                addr_q  <= ram_addr;
                wdata_q <= dwdata;
                fair    <= grant_d ? (fair || ireq) : 1'b0;
                irdy    <= !grant_d;
                drdy    <= grant_d;
                cnt     <= WAIT_CNT;
                state   <= (WAIT == 0) ? S_RESP : S_WAIT;
            end

            if (enter_resp) begin
                ivalid <= (resp_port == P_I);
                dvalid <= (resp_port == P_D);
            end
        end
    end

    // Read data is live from the RAM during the response cycle, then held.
    assign idata  = ivalid ? ram_rdata : idata_q;
    assign drdata = dvalid ? (we_q ? wdata_q : ram_rdata) : drdata_q;
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_sik_mem_responder.sv
// Scoreboard bench for sik_mem_responder: three instances with WAIT = 2, 0, 1.
module tb_sik_mem_responder;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [NI];
    logic        ireq   [NI];
    logic [15:0] iaddr  [NI];
    logic        irdy   [NI];
    logic        ivalid [NI];
    logic [15:0] idata  [NI];
    logic        dreq   [NI];
    logic        dwe    [NI];
    logic [15:0] daddr  [NI];
    logic [15:0] dwdata [NI];
    logic        drdy   [NI];
    logic        dvalid [NI];
    logic [15:0] drdata [NI];
    logic        busy   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sik_mem_responder #(
            .ADDR_W(16),
            .DATA_W(16),
            .WAIT  ((g == 0) ? 2 : ((g == 1) ? 0 : 1))
        ) u_dut (
            .clk   (clk),
            .reset (rst[g]),
            .ireq  (ireq[g]),
            .iaddr (iaddr[g]),
            .irdy  (irdy[g]),
            .ivalid(ivalid[g]),
            .idata (idata[g]),
            .dreq  (dreq[g]),
            .dwe   (dwe[g]),
            .daddr (daddr[g]),
            .dwdata(dwdata[g]),
            .drdy  (drdy[g]),
            .dvalid(dvalid[g]),
            .drdata(drdata[g]),
            .busy  (busy[g])
        );
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 1);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int          inst;
        logic [15:0] data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   rdy_i [NI];
    int   rdy_d [NI];
    bit   log_en = 1'b0;
    bit   glog[$];

    // Monitor: pops the expected response for each valid pulse and checks data and latency.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (irdy[k] === 1'b1) begin
                rdy_i[k] = cyc;
                if (log_en && k == 0) glog.push_back(1'b0);
            end
            if (drdy[k] === 1'b1) begin
                rdy_d[k] = cyc;
                if (log_en && k == 0) glog.push_back(1'b1);
            end
            if (ivalid[k] === 1'b1) begin
                if (iq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ivalid_unexpected: inst %0d idata %0h, none required", k, idata[k]);
                end else begin
                    e = iq.pop_front();
                    check("ivalid_inst", k, e.inst);
                    check("idata", idata[k], e.data);
                    check("ivalid_latency", cyc - rdy_i[k], wait_of(k));
                end
            end
            if (dvalid[k] === 1'b1) begin
                if (dq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dvalid_unexpected: inst %0d drdata %0h, none required", k, drdata[k]);
                end else begin
                    e = dq.pop_front();
                    check("dvalid_inst", k, e.inst);
                    check("drdata", drdata[k], e.data);
                    check("dvalid_latency", cyc - rdy_d[k], wait_of(k));
                end
            end
        end
    end

    task automatic wait_rdy(input int k, input bit is_d, output int rc);
        rc = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if ((is_d ? drdy[k] : irdy[k]) === 1'b1) begin
                rc = cyc;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL rdy_timeout: inst %0d port %s got no rdy, required within 64 cycles", k, is_d ? "D" : "I");
    endtask

    task automatic fetch(input int k, input logic [15:0] a, input logic [15:0] exp,
                         input bit hold, output int rc);
        iq.push_back('{inst: k, data: exp});
        ireq[k]  = 1'b1;
        iaddr[k] = a;
        wait_rdy(k, 1'b0, rc);
        if (!hold) ireq[k] = 1'b0;
    endtask

    task automatic dop(input int k, input bit we, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] exp, input bit expect_resp, input bit hold, output int rc);
        if (expect_resp) dq.push_back('{inst: k, data: (we ? wd : exp)});
        dreq[k]   = 1'b1;
        dwe[k]    = we;
        daddr[k]  = a;
        dwdata[k] = wd;
        wait_rdy(k, 1'b1, rc);
        if (!hold) dreq[k] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 64; n++) begin
            if (iq.size() == 0 && dq.size() == 0) break;
            @(negedge clk);
        end
        check("responses_outstanding", iq.size() + dq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int r2;
        int c0;
        bit exp_order [4];

        for (int k = 0; k < NI; k++) begin
            rst[k]    = 1'b1;
            ireq[k]   = 1'b0;
            iaddr[k]  = '0;
            dreq[k]   = 1'b0;
            dwe[k]    = 1'b0;
            daddr[k]  = '0;
            dwdata[k] = '0;
            rdy_i[k]  = 0;
            rdy_d[k]  = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("reset_busy", busy[k], 0);
            check("reset_irdy_ivalid", {irdy[k], ivalid[k]}, 0);
            check("reset_drdy_dvalid", {drdy[k], dvalid[k]}, 0);
            check("reset_data", {idata[k], drdata[k]}, 0);
        end
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);

        // Fetch only, WAIT=2
        dop(0, 1'b1, 16'h0010, 16'hA5C3, 16'h0, 1'b1, 1'b0, r);
        drain();
        c0 = cyc;
        fetch(0, 16'h0010, 16'hA5C3, 1'b0, r);
        check("irdy_latency", r, c0 + 1);
        repeat (2) @(negedge clk);
        check("busy_in_resp", busy[0], 1);
        @(negedge clk);
        check("busy_after_resp", busy[0], 0);
        drain();

        // Contention: both channels held for four grants
        dop(0, 1'b1, 16'h0100, 16'hD001, 16'h0, 1'b1, 1'b0, r);
        dop(0, 1'b1, 16'h0101, 16'hD002, 16'h0, 1'b1, 1'b0, r);
        dop(0, 1'b1, 16'h0200, 16'h1A01, 16'h0, 1'b1, 1'b0, r);
        dop(0, 1'b1, 16'h0201, 16'h1A02, 16'h0, 1'b1, 1'b0, r);
        drain();
        log_en = 1'b1;
        fork
            begin
                int ra;
                dop(0, 1'b0, 16'h0100, 16'h0, 16'hD001, 1'b1, 1'b1, ra);
                dop(0, 1'b0, 16'h0101, 16'h0, 16'hD002, 1'b1, 1'b0, ra);
            end
            begin
                int rb;
                fetch(0, 16'h0200, 16'h1A01, 1'b1, rb);
                fetch(0, 16'h0201, 16'h1A02, 1'b0, rb);
            end
        join
        drain();
        log_en = 1'b0;
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        check("grant_count", glog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < glog.size()) check($sformatf("grant_order_%0d", i), glog[i], exp_order[i]);
        end

        // Reset on the edge that would enter RESP of a store
        dop(0, 1'b1, 16'h0020, 16'h0000, 16'h0, 1'b1, 1'b0, r);
        dop(0, 1'b0, 16'h0100, 16'h0, 16'hD001, 1'b1, 1'b0, r);
        drain();
        dop(0, 1'b1, 16'h0020, 16'h1234, 16'h0, 1'b0, 1'b0, r);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("abort_busy", busy[0], 0);
        check("abort_valids", {irdy[0], ivalid[0], drdy[0], dvalid[0]}, 0);
        check("abort_idata", idata[0], 0);
        check("abort_drdata", drdata[0], 0);
        repeat (4) @(negedge clk);
        dop(0, 1'b0, 16'h0020, 16'h0, 16'h0000, 1'b1, 1'b0, r);
        drain();

        // WAIT=0: store/load at top of memory, address wrap, store-then-fetch ordering
        c0 = cyc;
        dop(1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0, 1'b1, 1'b0, r);
        check("drdy_latency_w0", r, c0 + 1);
        dop(1, 1'b0, 16'hFFFF, 16'h0, 16'hBEEF, 1'b1, 1'b0, r);
        drain();
        dop(1, 1'b1, 16'h0000, 16'h1111, 16'h0, 1'b1, 1'b0, r);
        dop(1, 1'b1, 16'hFFFF, 16'h7777, 16'h0, 1'b1, 1'b0, r);
        dop(1, 1'b0, 16'h0000, 16'h0, 16'h1111, 1'b1, 1'b0, r);
        dop(1, 1'b0, 16'hFFFF, 16'h0, 16'h7777, 1'b1, 1'b0, r);
        drain();
        fork
            begin
                int ra;
                dop(1, 1'b1, 16'h0042, 16'h5A5A, 16'h0, 1'b1, 1'b0, ra);
            end
            begin
                int rb;
                fetch(1, 16'h0042, 16'h5A5A, 1'b0, rb);
            end
        join
        drain();

        // WAIT=1: back-to-back fetches with ireq held
        dop(2, 1'b1, 16'h0000, 16'h0A0A, 16'h0, 1'b1, 1'b0, r);
        dop(2, 1'b1, 16'h0001, 16'h0B0B, 16'h0, 1'b1, 1'b0, r);
        drain();
        fetch(2, 16'h0000, 16'h0A0A, 1'b1, r);
        fetch(2, 16'h0001, 16'h0B0B, 1'b0, r2);
        check("b2b_second_irdy", r2, r + 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
